// File: rtl/add_selftest_ctrl_pkg.sv
// add_selftest_ctrl_pkg: shared types and widths for the add block self-test controller
package add_selftest_ctrl_pkg;
  localparam int IDX_W = 5;
  localparam int OP_W  = 2;
  localparam int ERR_W = 6;
  localparam int CNT_W = 2;
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
endpackage

// File: rtl/add_selftest_ctrl_golden_add2.sv
// golden_add2: reference 2-bit modulo-4 adder for expected sums
module golden_add2
  import add_selftest_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] i_in0,
  input  logic [OP_W-1:0] i_in1,
  output logic [OP_W-1:0] o_sum
);
  assign o_sum = i_in0 + i_in1;
endmodule

// File: rtl/add_selftest_ctrl.sv
// add_selftest_ctrl: sweeps all 32 {sel,in0,in1} vectors through an add block and tallies failures
module add_selftest_ctrl
  import add_selftest_ctrl_pkg::*;
#(
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [OP_W-1:0]  in0_add,
  output logic [OP_W-1:0]  in1_add,
  output logic             sel,
  input  logic [OP_W-1:0]  out0_add,
  input  logic             ok_add,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             first_fail_vld,
  output logic [IDX_W-1:0] first_fail_vec
);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(SETTLE_CYC - 1);
  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_err;
  logic             r_ffv;
  logic [IDX_W-1:0] r_ffvec;
  logic [OP_W-1:0]  w_exp;
  logic             w_fail;
  logic [ERR_W-1:0] w_err_nxt;
  golden_add2 u_gold (.i_in0(r_idx[3:2]), .i_in1(r_idx[1:0]), .o_sum(w_exp));
  assign w_fail    = !ok_add || (out0_add != w_exp);
  assign w_err_nxt = r_err + ERR_W'(w_fail);
  // operands come straight from the index flop so the add block only ever sees registered values
  assign sel            = r_idx[4];
  assign in0_add        = r_idx[3:2];
  assign in1_add        = r_idx[1:0];
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_cnt        = r_err;
  assign first_fail_vld = r_ffv;
  assign first_fail_vec = r_ffvec;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_ffv   <= 1'b0;
      r_ffvec <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: if (start) begin
          r_state <= SETTLE;
          r_idx   <= '0;
          r_cnt   <= LOAD;
          r_busy  <= 1'b1;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
          r_err   <= '0;
          r_ffv   <= 1'b0;
          r_ffvec <= '0;
        end
        SETTLE: if (r_cnt == '0) r_state <= SAMPLE; else r_cnt <= r_cnt - CNT_W'(1);
        SAMPLE: begin
          r_err <= w_err_nxt;
          if (w_fail && !r_ffv) begin
            r_ffv   <= 1'b1;
            r_ffvec <= r_idx;
          end
          if (r_idx == '1) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_nxt == '0);
          end else begin
            r_state <= SETTLE;
            r_idx   <= r_idx + IDX_W'(1);
            r_cnt   <= LOAD;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_add_selftest_ctrl.sv
// tb_add_selftest_ctrl: directed table-driven checks of the self-test controller
module tb_add_selftest_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  int mode = 0;
  int checks = 0, failures = 0;
  logic [1:0] in0_add, in1_add, out0_add;
  logic sel, ok_add, busy, done, pass, first_fail_vld;
  logic [5:0] err_cnt;
  logic [4:0] first_fail_vec;
  logic [1:0] in0_3, in1_3, out0_3;
  logic sel3, ok3, busy3, done3, pass3, ffv3;
  logic [5:0] err3;
  logic [4:0] ffvec3;

  always #5 clk = ~clk;

  // add block model: mode 0 correct, 1 ok_add low at idx 5, 2 sum stuck at 0
  assign out0_add = (mode == 2) ? 2'd0 : 2'(in0_add + in1_add);
  assign ok_add   = !(mode == 1 && {sel, in0_add, in1_add} == 5'd5);
  assign out0_3   = 2'(in0_3 + in1_3);
  assign ok3      = 1'b1;

  add_selftest_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in0_add(in0_add), .in1_add(in1_add), .sel(sel),
    .out0_add(out0_add), .ok_add(ok_add), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_fail_vld(first_fail_vld), .first_fail_vec(first_fail_vec));

  add_selftest_ctrl #(.SETTLE_CYC(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .in0_add(in0_3), .in1_add(in1_3), .sel(sel3),
    .out0_add(out0_3), .ok_add(ok3), .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3),
    .first_fail_vld(ffv3), .first_fail_vec(ffvec3));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int all_out();
    return {sel, in0_add, in1_add, busy, done, pass, err_cnt, first_fail_vld, first_fail_vec};
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic sweep(input int extra, output int lat, output int bc);
    lat = 0;
    bc = 0;
    while (!done && lat < 300) begin
      if (busy) bc++;
      if (lat == extra) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
  endtask

  typedef struct {
    int mode;
    int extra;
    int err;
    int pass;
    int ffv;
    int ffvec;
  } vec_t;
  vec_t tbl[4];

  initial begin
    int lat, bc, n, lat0;
    tbl[0] = '{0, -1, 0, 1, 0, 0};
    tbl[1] = '{1, -1, 1, 0, 1, 5};
    tbl[2] = '{2, -1, 24, 0, 1, 1};
    tbl[3] = '{0, 10, 0, 1, 0, 0};

    #12;
    chk("reset_outputs", all_out(), 0);
    chk("reset_busy3", int'(busy3), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("idle_no_start", int'(busy | done), 0);

    // SETTLE_CYC=3 instance swept alongside the default one
    pulse_start();
    n = 0;
    lat0 = 0;
    while (!done3 && n < 400) begin
      if (n == 3) chk("s3_idx_held_c3", int'({sel3, in0_3, in1_3}), 0);
      if (n == 4) chk("s3_idx_next_c4", int'({sel3, in0_3, in1_3}), 1);
      if (done && lat0 == 0) lat0 = n;
      @(posedge clk); #1;
      n++;
    end
    chk("s1_latency", lat0, 64);
    chk("s3_latency", n, 128);
    chk("s3_pass", int'(pass3), 1);
    chk("s3_err", int'(err3), 0);
    chk("s3_ffv", int'(ffv3), 0);

    foreach (tbl[i]) begin
      mode = tbl[i].mode;
      pulse_start();
      sweep(tbl[i].extra, lat, bc);
      chk($sformatf("v%0d_latency", i), lat, 64);
      chk($sformatf("v%0d_busy_cycles", i), bc, 64);
      chk($sformatf("v%0d_err", i), int'(err_cnt), tbl[i].err);
      chk($sformatf("v%0d_pass", i), int'(pass), tbl[i].pass);
      chk($sformatf("v%0d_ffv", i), int'(first_fail_vld), tbl[i].ffv);
      chk($sformatf("v%0d_ffvec", i), int'(first_fail_vec), tbl[i].ffvec);
      repeat (5) @(posedge clk);
      #1;
      chk($sformatf("v%0d_hold_err", i), int'(err_cnt), tbl[i].err);
      chk($sformatf("v%0d_hold_done", i), int'({done, busy}), 2);
    end

    // reset in the middle of a sweep
    mode = 0;
    pulse_start();
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("midreset_outputs", all_out(), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("midreset_idle", int'({busy, done}), 0);
    pulse_start();
    sweep(-1, lat, bc);
    chk("post_reset_latency", lat, 64);
    chk("post_reset_pass", int'(pass), 1);
    chk("post_reset_err", int'(err_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
